// File: rtl/enoc_pkg.sv
// Shared NoC types and mesh constants for the node interface and its queue.
package enoc_pkg;
  localparam int X_NODES_DEF = 4;
  localparam int Y_NODES_DEF = 4;
  localparam int NUM_NODES   = X_NODES_DEF * Y_NODES_DEF;
  localparam int DATA_W      = 32;
  localparam int ID_W        = 8;
  localparam int TS_W        = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   source;
    logic [ID_W-1:0]   dest;
    logic [TS_W-1:0]   timestamp;
    logic              valid;
  } packet_t;
endpackage

// File: rtl/enoc_fifo.sv
// Generic valid/enable FIFO; head is visible the cycle after it is written.
module enoc_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  T     in_data,
  input  logic in_val,
  output logic in_en,
  output T     out_data,
  output logic out_val,
  input  logic out_en,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic       push, pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_en    = !full;
  assign out_val  = !empty;
  assign out_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign push     = in_val && !full;
  assign pop      = out_val && out_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// File: rtl/enoc_node_interface.sv
// Mesh node endpoint: timestamps and queues injected packets, gathers receive statistics.
module enoc_node_interface
  import enoc_pkg::*;
#(
  parameter int X_NODES    = X_NODES_DEF,
  parameter int Y_NODES    = Y_NODES_DEF,
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  packet_t     i_pkt,
  input  logic        i_pkt_val,
  output logic        o_pkt_en,
  output packet_t     o_data,
  output logic        o_data_val,
  input  logic        i_en,
  input  packet_t     i_rx_data,
  input  logic        i_rx_val,
  output logic        o_rx_en,
  output logic [31:0] o_rx_count,
  output logic [47:0] o_latency_sum,
  output logic [15:0] o_drop_count,
  output logic        o_misroute
);
  localparam logic [31:0] NODES = 32'(X_NODES * Y_NODES);
  localparam logic [31:0] MY_ID = 32'(NODE_ID);

  logic            rdy;
  logic [TS_W-1:0] tstamp;
  logic            fifo_in_en, fifo_full, fifo_empty;
  logic            accept, dest_ok, push, drop, rx_hs;
  logic [TS_W-1:0] rx_lat;
  packet_t         wpkt;

  // rdy holds both handshakes off until the first edge after reset release.
  assign o_pkt_en = rdy && fifo_in_en;
  assign o_rx_en  = rdy;
  assign dest_ok  = 32'(i_pkt.dest) < NODES;
  assign accept   = i_pkt_val && o_pkt_en;
  assign push     = accept && dest_ok;
  assign drop     = accept && !dest_ok;
  assign rx_hs    = i_rx_val && o_rx_en;
  assign rx_lat   = tstamp - i_rx_data.timestamp;

  always_comb begin
    wpkt           = i_pkt;
    wpkt.timestamp = tstamp;
  end

  enoc_fifo #(.DEPTH(FIFO_DEPTH), .T(packet_t)) u_inj_q (
    .clk      (clk),
    .reset    (reset),
    .in_data  (wpkt),
    .in_val   (push),
    .in_en    (fifo_in_en),
    .out_data (o_data),
    .out_val  (o_data_val),
    .out_en   (i_en),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy           <= 1'b0;
      tstamp        <= '0;
      o_rx_count    <= '0;
      o_latency_sum <= '0;
      o_drop_count  <= '0;
      o_misroute    <= 1'b0;
    end else begin
      rdy    <= 1'b1;
      tstamp <= tstamp + 1'b1;
      if (drop && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
      if (rx_hs) begin
        if (o_rx_count != 32'hFFFF_FFFF) o_rx_count <= o_rx_count + 1'b1;
        o_latency_sum <= o_latency_sum + 48'(rx_lat);
        if (32'(i_rx_data.dest) != MY_ID) o_misroute <= 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{fifo_full, fifo_empty, i_rx_data.data, i_rx_data.source, i_rx_data.valid};
endmodule

// File: tb/tb_enoc_node_interface.sv
// Self-checking bench: per-cycle vector table, scoreboard on the injection path, directed corners.
module tb_enoc_node_interface;
  import enoc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  packet_t     i_pkt, o_data, i_rx_data;
  logic        i_pkt_val, o_pkt_en, o_data_val, i_en, i_rx_val, o_rx_en;
  logic [31:0] o_rx_count;
  logic [47:0] o_latency_sum;
  logic [15:0] o_drop_count;
  logic        o_misroute;

  int checks = 0;
  int errors = 0;
  int cyc;
  packet_t exp_q[$];

  enoc_node_interface #(.X_NODES(4), .Y_NODES(4), .NODE_ID(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .i_pkt(i_pkt), .i_pkt_val(i_pkt_val), .o_pkt_en(o_pkt_en),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en), .i_rx_data(i_rx_data),
    .i_rx_val(i_rx_val), .o_rx_en(o_rx_en), .o_rx_count(o_rx_count),
    .o_latency_sum(o_latency_sum), .o_drop_count(o_drop_count), .o_misroute(o_misroute)
  );

  always #5 clk = ~clk;

  // Bench copy of the timestamp counter: cycles since reset release.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop on dequeue handshake, push on accepted in-range enqueue.
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (o_data_val && i_en) begin
        if (exp_q.size() == 0) check("sb_underflow", 80'(exp_q.size()), 80'd1);
        else begin
          packet_t e;
          e = exp_q.pop_front();
          check("sb_data", 80'(o_data), 80'(e));
        end
      end
      if (i_pkt_val && o_pkt_en && i_pkt.dest < 8'd16) begin
        packet_t p;
        p = i_pkt;
        p.timestamp = cyc[15:0];
        exp_q.push_back(p);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_pkt(input logic val, input logic [7:0] dest, input logic [31:0] data);
    i_pkt_val = val;
    i_pkt = '0;
    if (val) begin
      i_pkt.data = data;
      i_pkt.source = 8'd3;
      i_pkt.dest = dest;
      i_pkt.timestamp = 16'hDEAD;
      i_pkt.valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_pkt(1'b0, 8'd0, 32'd0);
    i_en = 1'b0; i_rx_val = 1'b0; i_rx_data = '0;
    @(negedge clk);
    check("rst_pkt_en", 80'(o_pkt_en), 80'd0);
    check("rst_data_val", 80'(o_data_val), 80'd0);
    check("rst_data", 80'(o_data), 80'd0);
    check("rst_rx_en", 80'(o_rx_en), 80'd0);
    check("rst_stats", 80'({o_rx_count, o_latency_sum}), 80'd0);
    check("rst_drop_mis", 80'({o_drop_count, o_misroute}), 80'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        val;
    logic [7:0]  dest;
    logic        en;
    logic        exp_pkt_en;
    logic        exp_dval;
    logic [15:0] exp_drop;
  } vec_t;

  typedef struct {
    logic [7:0]  dest;
    logic [15:0] age;
  } rx_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[24];
    rx_t  rxv[3];
    logic [31:0] m_cnt;
    logic [47:0] m_lat;
    logic        m_mis;

    // Fill 4 with 5 offered, drain, refill, full+dequeue same cycle, then a bad dest.
    for (int i = 0; i < 24; i++) tbl[i] = '{1'b0, 8'd5, 1'b0, 1'b1, 1'b0, 16'd0};
    for (int i = 0; i < 5; i++)   begin tbl[i].val = 1'b1; tbl[i].exp_dval = (i != 0); end
    tbl[4].exp_pkt_en = 1'b0;
    for (int i = 5; i < 10; i++)  begin tbl[i].en = 1'b1; tbl[i].exp_dval = (i != 9); end
    tbl[5].exp_pkt_en = 1'b0;
    for (int i = 10; i < 16; i++) begin tbl[i].val = 1'b1; tbl[i].exp_dval = (i != 10); end
    tbl[14].en = 1'b1; tbl[14].exp_pkt_en = 1'b0;
    tbl[16].exp_pkt_en = 1'b0; tbl[16].exp_dval = 1'b1;
    for (int i = 17; i < 21; i++) begin tbl[i].en = 1'b1; tbl[i].exp_dval = 1'b1; end
    tbl[17].exp_pkt_en = 1'b0;
    tbl[22].val = 1'b1; tbl[22].dest = 8'd16;
    tbl[23].exp_drop = 16'd1;

    rxv[0] = '{8'd1, 16'd0};
    rxv[1] = '{8'd0, 16'd7};
    rxv[2] = '{8'd0, 16'd300};

    reset = 1'b1;
    drive_pkt(1'b0, 8'd0, 32'd0);
    i_en = 1'b0; i_rx_val = 1'b0; i_rx_data = '0;
    do_reset();

    // Single packet at counter 10, drained immediately.
    while (cyc < 10) tick();
    drive_pkt(1'b1, 8'd5, 32'h1234_5678);
    i_en = 1'b1;
    @(negedge clk);
    check("first_pkt_en", 80'(o_pkt_en), 80'd1);
    check("first_dval_c10", 80'(o_data_val), 80'd0);
    tick();
    drive_pkt(1'b0, 8'd0, 32'd0);
    @(negedge clk);
    check("first_dval_c11", 80'(o_data_val), 80'd1);
    check("first_ts", 80'(o_data.timestamp), 80'd10);
    tick();
    @(negedge clk);
    check("first_dval_c12", 80'(o_data_val), 80'd0);

    for (int i = 0; i < 24; i++) begin
      tick();
      drive_pkt(tbl[i].val, tbl[i].dest, 32'hA000_0000 + 32'(i));
      i_en = tbl[i].en;
      @(negedge clk);
      check($sformatf("vec%0d_pkt_en", i), 80'(o_pkt_en), 80'(tbl[i].exp_pkt_en));
      check($sformatf("vec%0d_dval", i), 80'(o_data_val), 80'(tbl[i].exp_dval));
      check($sformatf("vec%0d_drop", i), 80'(o_drop_count), 80'(tbl[i].exp_drop));
    end
    tick();
    drive_pkt(1'b0, 8'd0, 32'd0);
    i_en = 1'b0;
    check("sb_drained", 80'(exp_q.size()), 80'd0);

    // Receive path: latency wraps across the 16-bit counter boundary.
    do_reset();
    while (cyc < 3) tick();
    i_rx_val = 1'b1;
    i_rx_data = '{data: 32'h55, source: 8'd2, dest: 8'd0, timestamp: 16'hFFFE, valid: 1'b1};
    tick();
    i_rx_val = 1'b0;
    @(negedge clk);
    check("rx_count1", 80'(o_rx_count), 80'd1);
    check("rx_lat1", 80'(o_latency_sum), 80'd5);
    check("rx_mis1", 80'(o_misroute), 80'd0);
    m_cnt = 32'd1; m_lat = 48'd5; m_mis = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      i_rx_val = 1'b1;
      i_rx_data = '0;
      i_rx_data.dest = rxv[i].dest;
      i_rx_data.timestamp = cyc[15:0] - rxv[i].age;
      m_cnt = m_cnt + 1;
      m_lat = m_lat + 48'(rxv[i].age);
      m_mis = m_mis | (rxv[i].dest != 8'd0);
      tick();
      i_rx_val = 1'b0;
      @(negedge clk);
      check($sformatf("rx%0d_count", i), 80'(o_rx_count), 80'(m_cnt));
      check($sformatf("rx%0d_lat", i), 80'(o_latency_sum), 80'(m_lat));
      check($sformatf("rx%0d_mis", i), 80'(o_misroute), 80'(m_mis));
    end

    // Reset with three queued packets and nonzero stats.
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_pkt(1'b1, (i == 3) ? 8'd200 : 8'd2, 32'hB000_0000 + 32'(i));
    end
    tick();
    drive_pkt(1'b0, 8'd0, 32'd0);
    @(negedge clk);
    check("pre_rst_dval", 80'(o_data_val), 80'd1);
    check("pre_rst_drop", 80'(o_drop_count), 80'd1);
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_dval", 80'(o_data_val), 80'd0);
    check("mid_rst_pkt_en", 80'(o_pkt_en), 80'd0);
    check("mid_rst_stats", 80'({o_rx_count, o_drop_count, o_misroute}), 80'd0);
    check("mid_rst_lat", 80'(o_latency_sum), 80'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("post_rst_dval", 80'(o_data_val), 80'd0);
    check("post_rst_pkt_en", 80'(o_pkt_en), 80'd1);
    check("post_rst_rx_en", 80'(o_rx_en), 80'd1);
    check("post_rst_sb", 80'(exp_q.size()), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
